noc_link_rx: RTL and testbench

- Receiving end of one directional mesh link (valid/ready, 8-bit flit) between neighbouring nodes.
- Accepts flits from the upstream node's output side and buffers them in a small FIFO.
- Discards epidemic duplicates: a message ID already seen at this port is consumed and dropped.
- Presents unique flits to the node's routing core through its own valid/ready interface.
- One instance sits on each of the four sides (l/r/t/b) inside every node.

---
 rtl/noc_pkg.sv | 15 +
 rtl/noc_link_rx_if.sv | 12 +
 rtl/noc_flit_fifo.sv | 51 +++++
 rtl/noc_link_rx.sv | 86 ++++++++
 tb/tb_noc_link_rx.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared mesh NoC definitions: flit geometry, flit/ID types and the ID extractor.
package noc_pkg;

  localparam int FLIT_W = 8;
  localparam int ID_W   = 4;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [ID_W-1:0]   msg_id_t;

  // The message ID lives in the top bits of every flit.
  function automatic msg_id_t flit_id(input flit_t f);
    return f[FLIT_W-1 -: ID_W];
  endfunction

endpackage

// File: rtl/noc_link_rx_if.sv
// One direction of a valid/ready flit link; master drives valid/data, slave drives ready.
interface noc_link_rx_if;
  import noc_pkg::*;

  logic  valid;
  logic  ready;
  flit_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/noc_flit_fifo.sv
// Generic synchronous FIFO with push/pop and occupancy; head entry is read straight from storage.
module noc_flit_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rptr];
  assign count = cnt;

endmodule

// File: rtl/noc_link_rx.sv
// Mesh link receiver: buffers upstream flits and drops epidemic duplicates by message ID.
module noc_link_rx
  import noc_pkg::*;
#(
  parameter  int DATA_W     = FLIT_W,
  parameter  int DEPTH      = 4,
  parameter  int SEEN_DEPTH = 8,
  localparam int CW         = $clog2(DEPTH) + 1,
  localparam int SW         = $clog2(SEEN_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  noc_link_rx_if.slave   up,
  noc_link_rx_if.master  dn,
  input  logic           seen_clr,
  output logic [7:0]     drop_cnt,
  output logic [CW-1:0]  fifo_cnt
);

  msg_id_t               seen_id [SEEN_DEPTH];
  logic [SEEN_DEPTH-1:0] seen_vld;
  logic [SW-1:0]         wptr_s;
  msg_id_t               in_id;
  logic                  dup;
  logic                  accept;
  logic                  push;
  logic                  full;
  logic                  empty;

  assign in_id = flit_id(up.data);

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < SEEN_DEPTH; i++)
      if (seen_vld[i] && (seen_id[i] == in_id)) dup = 1'b1;
  end

  // Ready comes from occupancy alone, so duplicates are swallowed without stalling.
  assign up.ready = ~full;
  assign dn.valid = ~empty;
  assign accept   = up.valid & up.ready;
  assign push     = accept & ~dup;

  noc_flit_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (dn.ready),
    .din   (up.data),
    .dout  (dn.data),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // A clear coinciding with a unique insert leaves only that new ID, in entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_vld <= '0;
      wptr_s   <= '0;
      for (int i = 0; i < SEEN_DEPTH; i++) seen_id[i] <= '0;
    end else if (seen_clr) begin
      if (push) begin
        seen_id[0] <= in_id;
        seen_vld   <= SEEN_DEPTH'(1);
        wptr_s     <= SW'(1);
      end else begin
        seen_vld <= '0;
        wptr_s   <= '0;
      end
    end else if (push) begin
      seen_id[wptr_s]  <= in_id;
      seen_vld[wptr_s] <= 1'b1;
      wptr_s <= (wptr_s == SW'(SEEN_DEPTH - 1)) ? '0 : wptr_s + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  drop_cnt <= '0;
    else if (accept && dup && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_noc_link_rx.sv
// Directed bench for noc_link_rx: ordering, duplicate drop, full/back-pressure, seen table wrap/clear, saturation, reset.
module tb_noc_link_rx;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       seen_clr;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  noc_link_rx_if up_if ();
  noc_link_rx_if dn_if ();

  noc_link_rx dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up_if),
    .dn       (dn_if),
    .seen_clr (seen_clr),
    .drop_cnt (drop_cnt),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    up_if.valid = 1'b1;
    up_if.data  = d;
    tick();
    up_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; seen_clr = 1'b0; up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
    repeat (2) tick();
    vectors++; if (dn_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", dn_if.valid); end
    vectors++; if (up_if.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", up_if.ready); end
    vectors++; if (dn_if.data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h want 00", dn_if.data); end
    vectors++; if (fifo_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    dn_if.ready = 1'b1;
    send(8'h1A);
    vectors++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h1A) begin miscompares++; $display("[TB] FAIL basic_first: got v=%b d=%h want v=1 d=1a", dn_if.valid, dn_if.data); end
    send(8'h2B);
    vectors++; if (dn_if.data !== 8'h2B || fifo_cnt !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_second: got d=%h cnt=%0d want d=2b cnt=1", dn_if.data, fifo_cnt); end
    send(8'h3C);
    vectors++; if (dn_if.data !== 8'h3C || fifo_cnt !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_third: got d=%h cnt=%0d want d=3c cnt=1", dn_if.data, fifo_cnt); end
    tick();
    vectors++; if (dn_if.valid !== 1'b0 || fifo_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL basic_drain: got v=%b cnt=%0d want v=0 cnt=0", dn_if.valid, fifo_cnt); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL basic_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_dup();
    dn_if.ready = 1'b0;
    send(8'h5A);
    vectors++; if (fifo_cnt !== 3'd1 || dn_if.data !== 8'h5A) begin miscompares++; $display("[TB] FAIL dup_first: got cnt=%0d d=%h want cnt=1 d=5a", fifo_cnt, dn_if.data); end
    send(8'h5B);
    vectors++; if (fifo_cnt !== 3'd1) begin miscompares++; $display("[TB] FAIL dup_cnt: got %0d want 1", fifo_cnt); end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL dup_drop: got %0d want 1", drop_cnt); end
    vectors++; if (up_if.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dup_ready: got %b want 1", up_if.ready); end
    dn_if.ready = 1'b1;
    tick();
    vectors++; if (fifo_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL dup_drain: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_full();
    dn_if.ready = 1'b0;
    send(8'hA0); send(8'hB1); send(8'hC2); send(8'hD3);
    vectors++; if (fifo_cnt !== 3'd4 || up_if.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_state: got cnt=%0d rdy=%b want cnt=4 rdy=0", fifo_cnt, up_if.ready); end
    up_if.valid = 1'b1; up_if.data = 8'hE4;
    tick();
    vectors++; if (fifo_cnt !== 3'd4 || dn_if.data !== 8'hA0) begin miscompares++; $display("[TB] FAIL full_hold: got cnt=%0d d=%h want cnt=4 d=a0", fifo_cnt, dn_if.data); end
    dn_if.ready = 1'b1;
    tick();
    vectors++; if (fifo_cnt !== 3'd3 || dn_if.data !== 8'hB1 || up_if.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop: got cnt=%0d d=%h rdy=%b want cnt=3 d=b1 rdy=1", fifo_cnt, dn_if.data, up_if.ready); end
    tick();
    up_if.valid = 1'b0;
    vectors++; if (fifo_cnt !== 3'd3 || dn_if.data !== 8'hC2) begin miscompares++; $display("[TB] FAIL full_pushpop: got cnt=%0d d=%h want cnt=3 d=c2", fifo_cnt, dn_if.data); end
    tick();
    vectors++; if (dn_if.data !== 8'hD3) begin miscompares++; $display("[TB] FAIL full_order_d3: got %h want d3", dn_if.data); end
    tick();
    vectors++; if (dn_if.data !== 8'hE4) begin miscompares++; $display("[TB] FAIL full_order_e4: got %h want e4", dn_if.data); end
    tick();
    vectors++; if (fifo_cnt !== 3'd0 || dn_if.valid !== 1'b0 || drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL full_drain: got cnt=%0d v=%b drop=%0d want 0 0 1", fifo_cnt, dn_if.valid, drop_cnt); end
  endtask

  task automatic test_seen_wrap();
    logic [7:0] d;
    dn_if.ready = 1'b1;
    seen_clr = 1'b1; tick(); seen_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = {i[3:0], i[3:0]};
      send(d);
      vectors++; if (dn_if.data !== d || dn_if.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_id%0d: got v=%b d=%h want v=1 d=%h", i, dn_if.valid, dn_if.data, d); end
    end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL wrap_nodrop: got %0d want 1", drop_cnt); end
    send(8'h0F);
    vectors++; if (dn_if.data !== 8'h0F || drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL wrap_id0_again: got d=%h drop=%0d want d=0f drop=1", dn_if.data, drop_cnt); end
    send(8'h8F);
    vectors++; if (drop_cnt !== 8'd2 || dn_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_id8_dup: got drop=%0d v=%b want drop=2 v=0", drop_cnt, dn_if.valid); end
  endtask

  task automatic test_seen_clr();
    dn_if.ready = 1'b1;
    seen_clr = 1'b1; tick(); seen_clr = 1'b0;
    send(8'h7A);
    vectors++; if (dn_if.data !== 8'h7A) begin miscompares++; $display("[TB] FAIL clr_7a: got %h want 7a", dn_if.data); end
    seen_clr = 1'b1; send(8'h9B); seen_clr = 1'b0;
    vectors++; if (dn_if.data !== 8'h9B || drop_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL clr_insert: got d=%h drop=%0d want d=9b drop=2", dn_if.data, drop_cnt); end
    send(8'h7C);
    vectors++; if (dn_if.data !== 8'h7C || drop_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL clr_7_unique: got d=%h drop=%0d want d=7c drop=2", dn_if.data, drop_cnt); end
    send(8'h9D);
    vectors++; if (drop_cnt !== 8'd3 || dn_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_9_dup: got drop=%0d v=%b want drop=3 v=0", drop_cnt, dn_if.valid); end
    seen_clr = 1'b1; send(8'h9E); seen_clr = 1'b0;
    vectors++; if (drop_cnt !== 8'd4) begin miscompares++; $display("[TB] FAIL clr_preclear_dup: got %0d want 4", drop_cnt); end
    send(8'h9F);
    vectors++; if (dn_if.data !== 8'h9F || dn_if.valid !== 1'b1 || drop_cnt !== 8'd4) begin miscompares++; $display("[TB] FAIL clr_after: got d=%h v=%b drop=%0d want 9f 1 4", dn_if.data, dn_if.valid, drop_cnt); end
  endtask

  task automatic test_saturate_reset();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1; up_if.data = 8'h90;
    repeat (250) tick();
    vectors++; if (drop_cnt !== 8'd254) begin miscompares++; $display("[TB] FAIL sat_254: got %0d want 254", drop_cnt); end
    repeat (50) tick();
    up_if.valid = 1'b0;
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_255: got %0d want 255", drop_cnt); end
    dn_if.ready = 1'b0;
    send(8'h3A); send(8'h4B); send(8'h5C);
    vectors++; if (fifo_cnt !== 3'd3) begin miscompares++; $display("[TB] FAIL rst_prefill: got %0d want 3", fifo_cnt); end
    rst = 1'b1;
    #1;
    vectors++; if (dn_if.valid !== 1'b0 || fifo_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_async: got v=%b cnt=%0d want v=0 cnt=0", dn_if.valid, fifo_cnt); end
    vectors++; if (drop_cnt !== 8'd0 || up_if.ready !== 1'b1 || dn_if.data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_state: got drop=%0d rdy=%b d=%h want 0 1 00", drop_cnt, up_if.ready, dn_if.data); end
    tick();
    rst = 1'b0;
    send(8'h9A);
    vectors++; if (fifo_cnt !== 3'd1 || dn_if.data !== 8'h9A || drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_seen_lost: got cnt=%0d d=%h drop=%0d want 1 9a 0", fifo_cnt, dn_if.data, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_full();
    test_seen_wrap();
    test_seen_clr();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
